shiftregister_controller6: RTL

- Sequencer for the 6-bit right-shift register.
- Accepts a parallel word via a start/ready handshake and drives the register's preset-load and shift controls.
- Emits the word serially, LSB first, counts exactly WIDTH shifts, then pulses done.
- Sits between the register and its requester; the register's own clear is tied to this block's reset domain.

---
 rtl/shiftctrl_pkg.sv | 19 +
 rtl/shiftctrl_bitcounter.sv | 33 +++
 rtl/shiftregister_controller6.sv | 96 +++++++++
 3 files changed

// File: rtl/shiftctrl_pkg.sv
// Shared definitions for the 6-bit shift-register sequencer: state encoding,
// default width and the bit-counter width helper.
package shiftctrl_pkg;

    localparam int DEF_WIDTH = 6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Wide enough to hold WIDTH itself, so the count never wraps.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shiftctrl_bitcounter.sv
// Shift counter for the sequencer: cleared in LOAD, advanced in SHIFT,
// flags terminal count at WIDTH-1.
module shiftctrl_bitcounter
    import shiftctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic clockpulse,
    input  logic clear_,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = cnt_width(WIDTH);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clockpulse or negedge clear_) begin
        if (!clear_) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != CW'(WIDTH))) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/shiftregister_controller6.sv
// Sequencer for the 6-bit right-shift register: parallel load, WIDTH shifts
// LSB first, one-cycle done. Define SHIFTCTRL_ROTATE_EN for rotate mode.
module shiftregister_controller6
    import shiftctrl_pkg::*;
#(
    parameter int   WIDTH    = DEF_WIDTH,
    parameter logic FILL_BIT = 1'b0
) (
    input  logic             clockpulse,
    input  logic             clear_,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic             abort,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             sr_preset_enable,
    output logic [WIDTH-1:0] sr_preset,
    output logic             sr_serial_input,
    output logic             sr_shift_enable,
    input  logic [WIDTH-1:0] sr_q
);

    state_t state, state_nxt;
    logic   tc;

    // Only the LSB drives the serial stream; upper bits matter to the requester.
    logic sr_q_unused;
    assign sr_q_unused = ^sr_q[WIDTH-1:1];

    always_ff @(posedge clockpulse or negedge clear_) begin
        if (!clear_) begin
            state     <= S_IDLE;
            sr_preset <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start) begin
                sr_preset <= data;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt        = state;
        ready            = 1'b0;
        busy             = 1'b0;
        done             = 1'b0;
        bit_out          = 1'b0;
        bit_valid        = 1'b0;
        sr_preset_enable = 1'b0;
        sr_shift_enable  = 1'b0;
        sr_serial_input  = FILL_BIT;
        unique case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                busy             = 1'b1;
                sr_preset_enable = 1'b1;
                state_nxt        = abort ? S_IDLE : S_SHIFT;
            end
            S_SHIFT: begin
                busy            = 1'b1;
                bit_valid       = 1'b1;
                sr_shift_enable = 1'b1;
                bit_out         = sr_q[0];
`ifdef SHIFTCTRL_ROTATE_EN
                sr_serial_input = sr_q[0];
`else
                sr_serial_input = FILL_BIT;
`endif
                if (abort)   state_nxt = S_IDLE;
                else if (tc) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    shiftctrl_bitcounter #(.WIDTH(WIDTH)) u_bitcounter (
        .clockpulse (clockpulse),
        .clear_     (clear_),
        .clr        (state == S_LOAD),
        .en         (state == S_SHIFT),
        .tc         (tc)
    );

endmodule
